led_word_rx: RTL and testbench
==============================

LED_WORD_RX -- requirements
Module: led_word_rx

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 1251: clk cycles per serial bit.
REQ-002 SHALL have parameter HALF_TICKS, default BIT_TICKS/2 (625): start-bit mid-point offset.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rxd  input  1  serial line, asynchronous to clk, idles low.
REQ-006 SHALL have port data  output  32  last good received word.
REQ-007 SHALL have port data_neg  output  32  two's-complement negation of data (combinational from data).
REQ-008 SHALL have port valid  output  1  one-cycle pulse when data updates.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; rxd_s (2nd flop) is the only sampled value.
REQ-012 SHALL define the frame as: start bit 1, then 32 data bits LSB first (bit 0 first), then stop bit 0; each bit lasts BIT_TICKS cycles.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP with a tick counter (width ceil(log2(BIT_TICKS))) and a 5-bit bit index.
REQ-014 IDLE: when rxd_s==1, go to START with counter=0.
REQ-015 START: when counter==HALF_TICKS-1, go to DATA with counter=0 and index=0 if rxd_s==1; otherwise go to IDLE (glitch reject).
REQ-016 DATA: when counter==BIT_TICKS-1, write rxd_s into shift[index] and clear counter; once index 31 is written, go to STOP; otherwise increment index.
REQ-017 STOP: when counter==BIT_TICKS-1, sample rxd_s and go to IDLE.
REQ-018 STOP with rxd_s==0: data<=shift and valid=1 for exactly the next cycle.
REQ-019 STOP with rxd_s==1: frame_err=1 for one cycle; data and valid unchanged.
REQ-020 Otherwise the counter SHALL increment by 1 each cycle in START/DATA/STOP and wrap to 0 only as stated above.
REQ-021 valid and frame_err SHALL never be high together.
REQ-022 A start bit SHALL be accepted in the cycle after the return to IDLE, so back-to-back frames are supported.
REQ-023 The shift register SHALL be internal; partial words SHALL never appear on data.
REQ-024 data_neg SHALL equal (~data)+1 modulo 2^32, so 0 maps to 0 and 0x80000000 maps to 0x80000000.

Reset
REQ-025 While rst is high, SHALL set state=IDLE, counter=0, index=0, shift=0, data=0, valid=0, frame_err=0, and both synchronizer flops=0; data_neg is then 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; reception resumes on the next start bit after release.

Structure
REQ-027 SHALL place the FSM state encoding and the default BIT_TICKS constant in the shared package/include used by the serial-LED blocks.
REQ-028 SHALL instantiate the existing negate32bit module (In=data, Out=data_neg) as its one sub-module; no other sub-modules.

Verification
REQ-029 Send frame 0xCB2AEACF with BIT_TICKS=1251 -> one valid pulse, data=0xCB2AEACF, data_neg=0x34D51531, frame_err stays 0.
REQ-030 Send a 300-cycle high glitch on rxd in IDLE -> FSM returns to IDLE from START; no valid, busy falls.
REQ-031 Send frame 0x00000001 with stop bit held 1 -> frame_err pulses once; data keeps its previous value.
REQ-032 Send frames 0xFFFFFFFF then 0x80000000 back-to-back -> two valid pulses; data_neg=0x00000001, then 0x80000000.
REQ-033 Assert rst during data bit 17, release, then send 0x12345678 -> no pulse before the release; after it, data=0x12345678 and data_neg=0xEDCBA988.
REQ-034 Run with BIT_TICKS=8 and HALF_TICKS=4 sending 0xA5A5A5A5 -> valid occurs 2 + 4 + 33*8 cycles after the rxd rising edge (sync + half + data/stop), ±1.

Source files
------------

// File: rtl/led_word_rx_pkg.sv
// Shared definitions for the serial-LED word receiver: default bit timing and FSM encoding.
`timescale 1ns/1ps
package led_word_rx_pkg;

  localparam int unsigned BitTicksDefault = 1251;
  localparam int unsigned WordBits        = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/led_word_rx_if.sv
// Serial line in, received word and status out; slave is the receiver side.
`timescale 1ns/1ps
interface led_word_rx_if;

  logic        rxd;
  logic [31:0] data;
  logic [31:0] data_neg;
  logic        valid;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  rxd,
    output data,
    output data_neg,
    output valid,
    output frame_err,
    output busy
  );

  modport master (
    output rxd,
    input  data,
    input  data_neg,
    input  valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/negate32bit.sv
// Two's-complement negation of a 32-bit word.
`timescale 1ns/1ps
module negate32bit (
  input  logic [31:0] In,
  output logic [31:0] Out
);

  assign Out = ~In + 32'd1;

endmodule

// File: rtl/led_word_rx.sv
// Receives 32-bit words framed as start(1), LSB-first data, stop(0) on an idle-low serial line.
`timescale 1ns/1ps
module led_word_rx
  import led_word_rx_pkg::*;
#(
  parameter int unsigned BIT_TICKS  = BitTicksDefault,
  parameter int unsigned HALF_TICKS = BIT_TICKS / 2
) (
  input  logic          clk,
  input  logic          rst,
  led_word_rx_if.slave  rx_io
);

  localparam int unsigned CntW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_TICKS - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_TICKS - 1);
  localparam logic [4:0]      IdxLast  = 5'(WordBits - 1);

  logic [1:0]          sync_q;
  logic                rxd_s;
  rx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [4:0]          idx_q, idx_d;
  logic [WordBits-1:0] shift_q, shift_d;
  logic [WordBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic [WordBits-1:0] data_neg;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_io.rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rxd_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Re-check the line at mid start bit so short glitches are dropped.
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (!rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  negate32bit u_negate (
    .In  (data_q),
    .Out (data_neg)
  );

  assign rx_io.data      = data_q;
  assign rx_io.data_neg  = data_neg;
  assign rx_io.valid     = valid_q;
  assign rx_io.frame_err = ferr_q;
  assign rx_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_led_word_rx.sv
// Directed bench: a fast-timing receiver for most frames plus a default-timing one.
`timescale 1ns/1ps
module tb_led_word_rx;

  localparam int ShortTicks = 8;
  localparam int LongTicks  = 1251;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_word_rx_if rx_s ();
  led_word_rx_if rx_l ();

  led_word_rx #(
    .BIT_TICKS  (ShortTicks),
    .HALF_TICKS (4)
  ) dut_s (
    .clk   (clk),
    .rst   (rst),
    .rx_io (rx_s)
  );

  led_word_rx dut_l (
    .clk   (clk),
    .rst   (rst),
    .rx_io (rx_l)
  );

  typedef struct {
    logic [31:0] word;
    logic        stop;
    int          exp_v;
    int          exp_e;
    logic [31:0] exp_data;
    logic [31:0] exp_neg;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;

  int vcnt_s = 0, ecnt_s = 0, vcnt_l = 0, ecnt_l = 0, both_cnt = 0;
  logic [31:0] hist_s[$];

  int v0, e0, h0, cyc;
  bit got;

  always @(negedge clk) begin
    if (rx_s.valid) begin
      vcnt_s <= vcnt_s + 1;
      hist_s.push_back(rx_s.data_neg);
    end
    if (rx_s.frame_err) ecnt_s <= ecnt_s + 1;
    if (rx_l.valid) vcnt_l <= vcnt_l + 1;
    if (rx_l.frame_err) ecnt_l <= ecnt_l + 1;
    if ((rx_s.valid && rx_s.frame_err) || (rx_l.valid && rx_l.frame_err))
      both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit lng, input logic b, input int n);
    if (lng) rx_l.rxd = b;
    else     rx_s.rxd = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit lng, input logic [31:0] w, input logic stop_b);
    int t;
    t = lng ? LongTicks : ShortTicks;
    drive(lng, 1'b1, t);
    for (int i = 0; i < 32; i++) drive(lng, w[i], t);
    drive(lng, stop_b, t);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 1, 0, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{32'h0000_0001, 1'b1, 0, 1, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'h7FFF_FFFF, 1'b0, 1, 0, 32'h7FFF_FFFF, 32'h8000_0001};
    vecs[3] = '{32'h0000_0001, 1'b1, 0, 1, 32'h7FFF_FFFF, 32'h8000_0001};
    vecs[4] = '{32'hDEAD_BEEF, 1'b0, 1, 0, 32'hDEAD_BEEF, 32'h2152_4111};
    vecs[5] = '{32'h1357_9BDF, 1'b0, 1, 0, 32'h1357_9BDF, 32'hECA8_6421};

    rx_s.rxd = 1'b0;
    rx_l.rxd = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_s.data, 32'h0);
    chk("rst_data_neg", rx_s.data_neg, 32'h0);
    chk("rst_valid", {31'b0, rx_s.valid}, 32'h0);
    chk("rst_frame_err", {31'b0, rx_s.frame_err}, 32'h0);
    chk("rst_busy", {31'b0, rx_s.busy}, 32'h0);
    chk("rst_busy_long", {31'b0, rx_l.busy}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Latency from rxd rising edge to valid with fast timing.
    v0 = vcnt_s;
    got = 1'b0;
    cyc = 0;
    fork
      send_frame(1'b0, 32'hA5A5_A5A5, 1'b0);
      begin
        while (cyc < 400 && !got) begin
          @(posedge clk);
          #1;
          cyc++;
          if (rx_s.valid) got = 1'b1;
        end
      end
    join
    drive(1'b0, 1'b0, 16);
    chk("latency_seen", {31'b0, got}, 32'h1);
    chk("latency_in_window", {31'b0, (cyc >= 269 && cyc <= 271)}, 32'h1);
    chk("a5_data", rx_s.data, 32'hA5A5_A5A5);
    chk("a5_data_neg", rx_s.data_neg, 32'h5A5A_5A5B);
    chk("a5_pulses", vcnt_s - v0, 32'd1);

    for (int k = 0; k < 6; k++) begin
      v0 = vcnt_s;
      e0 = ecnt_s;
      send_frame(1'b0, vecs[k].word, vecs[k].stop);
      drive(1'b0, 1'b0, 16);
      chk($sformatf("vec%0d_valid_pulses", k), vcnt_s - v0, vecs[k].exp_v);
      chk($sformatf("vec%0d_err_pulses", k), ecnt_s - e0, vecs[k].exp_e);
      chk($sformatf("vec%0d_data", k), rx_s.data, vecs[k].exp_data);
      chk($sformatf("vec%0d_data_neg", k), rx_s.data_neg, vecs[k].exp_neg);
      chk($sformatf("vec%0d_busy", k), {31'b0, rx_s.busy}, 32'h0);
    end

    // Back-to-back frames with no idle gap.
    v0 = vcnt_s;
    h0 = hist_s.size();
    send_frame(1'b0, 32'hFFFF_FFFF, 1'b0);
    send_frame(1'b0, 32'h8000_0000, 1'b0);
    drive(1'b0, 1'b0, 16);
    chk("b2b_pulses", vcnt_s - v0, 32'd2);
    if (hist_s.size() >= h0 + 2) begin
      chk("b2b_neg_first", hist_s[h0], 32'h0000_0001);
      chk("b2b_neg_second", hist_s[h0+1], 32'h8000_0000);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL b2b_history: got %0d entries, expected %0d", hist_s.size() - h0, 2);
    end
    chk("b2b_data", rx_s.data, 32'h8000_0000);

    // Reset in the middle of data bit 17.
    v0 = vcnt_s;
    e0 = ecnt_s;
    drive(1'b0, 1'b1, ShortTicks);
    for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, ShortTicks);
    drive(1'b0, 1'b1, 4);
    chk("pre_rst_busy", {31'b0, rx_s.busy}, 32'h1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_data", rx_s.data, 32'h0);
    chk("midrst_data_neg", rx_s.data_neg, 32'h0);
    chk("midrst_busy", {31'b0, rx_s.busy}, 32'h0);
    rx_s.rxd = 1'b0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 3 * ShortTicks);
    chk("midrst_valid_pulses", vcnt_s - v0, 32'd0);
    chk("midrst_err_pulses", ecnt_s - e0, 32'd0);
    send_frame(1'b0, 32'h1234_5678, 1'b0);
    drive(1'b0, 1'b0, 16);
    chk("postrst_pulses", vcnt_s - v0, 32'd1);
    chk("postrst_data", rx_s.data, 32'h1234_5678);
    chk("postrst_data_neg", rx_s.data_neg, 32'hEDCB_A988);

    // Default timing: glitch rejection, then one full frame.
    v0 = vcnt_l;
    e0 = ecnt_l;
    drive(1'b1, 1'b1, 300);
    chk("glitch_busy_high", {31'b0, rx_l.busy}, 32'h1);
    drive(1'b1, 1'b0, 700);
    chk("glitch_busy_low", {31'b0, rx_l.busy}, 32'h0);
    chk("glitch_valid_pulses", vcnt_l - v0, 32'd0);
    chk("glitch_err_pulses", ecnt_l - e0, 32'd0);
    send_frame(1'b1, 32'hCB2A_EACF, 1'b0);
    drive(1'b1, 1'b0, 16);
    chk("long_valid_pulses", vcnt_l - v0, 32'd1);
    chk("long_err_pulses", ecnt_l - e0, 32'd0);
    chk("long_data", rx_l.data, 32'hCB2A_EACF);
    chk("long_data_neg", rx_l.data_neg, 32'h34D5_1531);

    chk("valid_err_overlap", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
